// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared definitions for the motor channel array: register map,
//               CTRL/STATUS bit positions, quadrature state encoding and the
//               quadrature step decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

    // Per-channel register map
    localparam logic [1:0] REG_PERIOD   = 2'd0;
    localparam logic [1:0] REG_DUTY     = 2'd1;
    localparam logic [1:0] REG_POSITION = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    // CTRL/STATUS bit indices
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_ERR_BIT = 1;
    localparam int CTRL_DIR_BIT = 2;

    // Quadrature state {A,B}; forward order is 00 -> 01 -> 11 -> 10 -> 00
    typedef enum logic [1:0] {
        QEI_S00 = 2'b00,
        QEI_S01 = 2'b01,
        QEI_S11 = 2'b11,
        QEI_S10 = 2'b10
    } qei_state_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2,
        STEP_ERR  = 2'd3
    } qei_step_t;

    // Successor of a state in the forward direction
    function automatic qei_state_t qei_next_fwd(input qei_state_t s);
        qei_state_t n;
        case (s)
            QEI_S00: n = QEI_S01;
            QEI_S01: n = QEI_S11;
            QEI_S11: n = QEI_S10;
            default: n = QEI_S00;
        endcase
        return n;
    endfunction

    // Classify the transition prev -> cur; a two-bit change is an error
    function automatic qei_step_t qei_decode(input qei_state_t prev, input qei_state_t cur);
        qei_step_t r;
        if (cur == prev)
            r = STEP_NONE;
        else if (cur == qei_next_fwd(prev))
            r = STEP_UP;
        else if (prev == qei_next_fwd(cur))
            r = STEP_DOWN;
        else
            r = STEP_ERR;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/motor_channel.sv
`default_nettype none
// ============================================================================
// Module      : motor_channel
// Description : One motor channel: QEI synchroniser, decoder and position
//               counter, double-buffered PWM generator and complementary
//               output stage. Dead-time insertion is built when the macro
//               MOTOR_DEADTIME_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_channel
    import motor_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PWM_W    = 16
`ifdef MOTOR_DEADTIME_EN
    ,
    parameter int DEADTIME = 8
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_qei_a,
    input  logic             i_qei_b,
    input  logic             i_wr_en,
    input  logic [1:0]       i_wr_addr,
    input  logic [31:0]      i_wr_data,
    output logic [PWM_W-1:0] o_period,
    output logic [PWM_W-1:0] o_duty,
    output logic [CNT_W-1:0] o_position,
    output logic             o_enable,
    output logic             o_qei_err,
    output logic             o_direction,
    output logic             o_pwm_high,
    output logic             o_pwm_low
);

    localparam logic [CNT_W-1:0] c_POS_ONE = CNT_W'(1);
    localparam logic [PWM_W-1:0] c_CNT_ONE = PWM_W'(1);

    logic             r_a_meta, r_a_sync, r_b_meta, r_b_sync;
    qei_state_t       r_qei_prev;
    logic [CNT_W-1:0] r_position;
    logic             r_dir, r_err, r_enable;
    logic [PWM_W-1:0] r_period_sh, r_duty_sh, r_period, r_duty, r_cnt;
    logic             r_pwm_high, r_pwm_low;

    qei_state_t       w_qei_cur;
    qei_step_t        w_step;
    logic             w_wr_period, w_wr_duty, w_wr_pos, w_wr_ctrl;
    logic [PWM_W-1:0] w_period_sh_nxt, w_duty_sh_nxt;
    logic             w_wrap, w_raw;

    assign w_wr_period = i_wr_en && (i_wr_addr == REG_PERIOD);
    assign w_wr_duty   = i_wr_en && (i_wr_addr == REG_DUTY);
    assign w_wr_pos    = i_wr_en && (i_wr_addr == REG_POSITION);
    assign w_wr_ctrl   = i_wr_en && (i_wr_addr == REG_CTRL);

    assign w_qei_cur = qei_state_t'({r_a_sync, r_b_sync});
    assign w_step    = qei_decode(r_qei_prev, w_qei_cur);

    // Two-flop synchronisers for the asynchronous encoder inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a_meta <= 1'b0;
            r_a_sync <= 1'b0;
            r_b_meta <= 1'b0;
            r_b_sync <= 1'b0;
        end else begin
            r_a_meta <= i_qei_a;
            r_a_sync <= r_a_meta;
            r_b_meta <= i_qei_b;
            r_b_sync <= r_b_meta;
        end
    end

    // Decoder state, position counter, direction, sticky error and enable
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_qei_prev <= QEI_S00;
            r_position <= '0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
            r_enable   <= 1'b0;
        end else begin
            r_qei_prev <= w_qei_cur;
            // A software load takes priority over a count in the same cycle
            if (w_wr_pos)
                r_position <= CNT_W'($signed(i_wr_data));
            else if (w_step == STEP_UP)
                r_position <= r_position + c_POS_ONE;
            else if (w_step == STEP_DOWN)
                r_position <= r_position - c_POS_ONE;
            if (w_step == STEP_UP)
                r_dir <= 1'b1;
            else if (w_step == STEP_DOWN)
                r_dir <= 1'b0;
            // A new error beats a simultaneous clear
            if (w_step == STEP_ERR)
                r_err <= 1'b1;
            else if (w_wr_ctrl && i_wr_data[CTRL_ERR_BIT])
                r_err <= 1'b0;
            if (w_wr_ctrl)
                r_enable <= i_wr_data[CTRL_EN_BIT];
        end
    end

    assign w_period_sh_nxt = w_wr_period ? i_wr_data[PWM_W-1:0] : r_period_sh;
    assign w_duty_sh_nxt   = w_wr_duty   ? i_wr_data[PWM_W-1:0] : r_duty_sh;
    assign w_wrap          = i_tick && (r_cnt >= r_period);
    assign w_raw           = r_enable && (r_cnt < r_duty);

    // Shadow/active PERIOD and DUTY plus the prescaled PWM counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_period_sh <= '0;
            r_duty_sh   <= '0;
            r_period    <= '0;
            r_duty      <= '0;
            r_cnt       <= '0;
        end else begin
            r_period_sh <= w_period_sh_nxt;
            r_duty_sh   <= w_duty_sh_nxt;
            // Active values track the shadows while idle, else load at wrap
            if (!r_enable || w_wrap) begin
                r_period <= w_period_sh_nxt;
                r_duty   <= w_duty_sh_nxt;
            end
            if (!r_enable)
                r_cnt <= '0;
            else if (i_tick)
                r_cnt <= w_wrap ? '0 : r_cnt + c_CNT_ONE;
        end
    end

`ifdef MOTOR_DEADTIME_EN
    localparam int                c_DT_W    = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;
    localparam logic [c_DT_W-1:0] c_DT_LOAD = c_DT_W'(DEADTIME - 1);
    localparam logic [c_DT_W-1:0] c_DT_ONE  = c_DT_W'(1);

    logic              r_raw_d;
    logic [c_DT_W-1:0] r_dt_cnt;

    // Any raw edge blanks both sides for DEADTIME clocks before following raw
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_raw_d    <= 1'b0;
            r_dt_cnt   <= '0;
            r_pwm_high <= 1'b0;
            r_pwm_low  <= 1'b0;
        end else begin
            r_raw_d <= w_raw;
            if (w_raw != r_raw_d) begin
                r_dt_cnt   <= c_DT_LOAD;
                r_pwm_high <= 1'b0;
                r_pwm_low  <= 1'b0;
            end else if (r_dt_cnt != '0) begin
                r_dt_cnt   <= r_dt_cnt - c_DT_ONE;
                r_pwm_high <= 1'b0;
                r_pwm_low  <= 1'b0;
            end else begin
                r_pwm_high <= w_raw;
                r_pwm_low  <= r_enable && !w_raw;
            end
        end
    end
`else
    // Complementary outputs registered one clock after raw
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pwm_high <= 1'b0;
            r_pwm_low  <= 1'b0;
        end else begin
            r_pwm_high <= w_raw;
            r_pwm_low  <= r_enable && !w_raw;
        end
    end
`endif

    assign o_period    = r_period_sh;
    assign o_duty      = r_duty_sh;
    assign o_position  = r_position;
    assign o_enable    = r_enable;
    assign o_qei_err   = r_err;
    assign o_direction = r_dir;
    assign o_pwm_high  = r_pwm_high;
    assign o_pwm_low   = r_pwm_low;

endmodule
`default_nettype wire

// File: rtl/motor_channel_array.sv
`default_nettype none
// ============================================================================
// Module      : motor_channel_array
// Description : N_CH motor channels (QEI + complementary PWM) behind a simple
//               synchronous register port, with a shared clock-enable
//               prescaler. Define MOTOR_DEADTIME_EN to build the dead-time
//               stage; otherwise DEADTIME has no effect on the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_channel_array
    import motor_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int CNT_W    = 32,
    parameter int PWM_W    = 16,
    parameter int PRESCALE = 4,
    parameter int DEADTIME = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N_CH-1:0] qei_a,
    input  logic [N_CH-1:0] qei_b,
    output logic [N_CH-1:0] pwm_high,
    output logic [N_CH-1:0] pwm_low,
    input  logic            wr_en,
    input  logic [3:0]      wr_ch,
    input  logic [1:0]      wr_addr,
    input  logic [31:0]     wr_data,
    input  logic            rd_en,
    input  logic [3:0]      rd_ch,
    input  logic [1:0]      rd_addr,
    output logic [31:0]     rd_data,
    output logic            rd_valid,
    output logic [N_CH-1:0] qei_err
);

    if ((N_CH < 1) || (N_CH > 16) || (PRESCALE < 1) || (DEADTIME < 1) ||
        (PWM_W < 1) || (PWM_W > 32) || (CNT_W < 2)) begin : g_param_check
        $error("motor_channel_array: parameter out of range");
    end

    localparam int                 c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);

    logic [c_PRE_W-1:0] r_pre_cnt;
    logic               r_tick;

    logic [PWM_W-1:0] w_period [N_CH];
    logic [PWM_W-1:0] w_duty   [N_CH];
    logic [CNT_W-1:0] w_pos    [N_CH];
    logic             w_en     [N_CH];
    logic             w_err    [N_CH];
    logic             w_dir    [N_CH];
    logic [31:0]      w_rd_word;

    // Free-running prescaler producing a one-clock tick every PRESCALE clocks
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (r_pre_cnt == c_PRE_LAST) begin
            r_pre_cnt <= '0;
            r_tick    <= 1'b1;
        end else begin
            r_pre_cnt <= r_pre_cnt + c_PRE_ONE;
            r_tick    <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        motor_channel #(
            .CNT_W    (CNT_W),
            .PWM_W    (PWM_W)
`ifdef MOTOR_DEADTIME_EN
            ,
            .DEADTIME (DEADTIME)
`endif
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .i_tick      (r_tick),
            .i_qei_a     (qei_a[gi]),
            .i_qei_b     (qei_b[gi]),
            .i_wr_en     (wr_en && (wr_ch == 4'(gi))),
            .i_wr_addr   (wr_addr),
            .i_wr_data   (wr_data),
            .o_period    (w_period[gi]),
            .o_duty      (w_duty[gi]),
            .o_position  (w_pos[gi]),
            .o_enable    (w_en[gi]),
            .o_qei_err   (w_err[gi]),
            .o_direction (w_dir[gi]),
            .o_pwm_high  (pwm_high[gi]),
            .o_pwm_low   (pwm_low[gi])
        );
        assign qei_err[gi] = w_err[gi];
    end

    // Read mux; an unpopulated channel number yields zero
    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == 4'(i)) begin
                case (rd_addr)
                    REG_PERIOD:   w_rd_word = 32'(w_period[i]);
                    REG_DUTY:     w_rd_word = 32'(w_duty[i]);
                    REG_POSITION: w_rd_word = 32'($signed(w_pos[i]));
                    default: begin
                        w_rd_word[CTRL_EN_BIT]  = w_en[i];
                        w_rd_word[CTRL_ERR_BIT] = w_err[i];
                        w_rd_word[CTRL_DIR_BIT] = w_dir[i];
                    end
                endcase
            end
        end
    end

    // Registered read port; data reflects state before any same-cycle write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= w_rd_word;
        end
    end

endmodule
`default_nettype wire
